// File: rtl/button_debounce.sv
// Pushbutton conditioner: synchronises a raw key pin and only changes the
// clean press level Bo after the new level has held for DEBOUNCE_CYCLES.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Bin,
    output logic Bo,
    output logic Busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic RELEASED_LEVEL = ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser chain on the raw pin
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = Bin;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    // Reloading the released level means a key held through reset must
    // requalify from scratch once reset drops.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_reg <= {SYNC_STAGES{RELEASED_LEVEL}};
        end else begin
            sync_reg <= sync_next;
        end
    end

    logic press;
    assign press = sync_reg[SYNC_STAGES-1] ^ ACTIVE_LOW;

    // ------------------------------------------------------------------
    // Qualification FSM
    // ------------------------------------------------------------------
    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic            bo_reg;
    logic            busy_reg;

    always_comb begin
        state_next = state_reg;
        count_next = '0;
        case (state_reg)
            ST_RELEASED: begin
                if (press) begin
                    state_next = ST_PRESS_WAIT;
                end
            end
            ST_PRESS_WAIT: begin
                if (!press) begin
                    state_next = ST_RELEASED;
                end else if (count_reg == COUNT_LAST) begin
                    state_next = ST_PRESSED;
                end else begin
                    count_next = count_reg + COUNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!press) begin
                    state_next = ST_RELEASE_WAIT;
                end
            end
            ST_RELEASE_WAIT: begin
                if (press) begin
                    state_next = ST_PRESSED;
                end else if (count_reg == COUNT_LAST) begin
                    state_next = ST_RELEASED;
                end else begin
                    count_next = count_reg + COUNT_ONE;
                end
            end
            default: begin
                state_next = ST_RELEASED;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they track
    // the state register exactly with no path back to the pin.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= ST_RELEASED;
            count_reg <= '0;
            bo_reg    <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            bo_reg    <= (state_next == ST_PRESSED) || (state_next == ST_RELEASE_WAIT);
            busy_reg  <= (state_next == ST_PRESS_WAIT) || (state_next == ST_RELEASE_WAIT);
        end
    end

    assign Bo   = bo_reg;
    assign Busy = busy_reg;

endmodule
